// File: rtl/vga_timing_engine_if.sv
// Pixel fetch handshake between the VGA timing engine and its pixel source.
//   req_valid   engine -> source : one-clk strobe that requests one pixel
//   req_x/req_y engine -> source : column/row of the requested pixel
//   in_valid    source -> engine : the source colour is valid
//   in_r/g/b    source -> engine : source colour, COLOR_W bits per channel
// The engine connects through the master modport and the source through the
// slave modport.
interface vga_timing_engine_if #(
  parameter int COLOR_W = 4
);
  logic               req_valid;
  logic [10:0]        req_x;
  logic [10:0]        req_y;
  logic               in_valid;
  logic [COLOR_W-1:0] in_r;
  logic [COLOR_W-1:0] in_g;
  logic [COLOR_W-1:0] in_b;

  modport master (
    output req_valid, req_x, req_y,
    input  in_valid, in_r, in_g, in_b
  );

  modport slave (
    input  req_valid, req_x, req_y,
    output in_valid, in_r, in_g, in_b
  );
endinterface

// File: rtl/vga_timing_engine.sv
// VGA timing engine.
// A clock divider produces pixel ticks. On each tick the h/v raster counters
// advance, an in-frame position raises a pixel fetch request, and raw
// sync/de/position enter a FETCH_LAT-deep pipeline. FETCH_LAT ticks after a
// request, the delayed sync/de and the source colour are registered onto the
// outputs. Active pixels without valid source data are blanked and flagged as
// an underrun.
// Ports:
//   clk             clock
//   reset           synchronous, active-low reset
//   fetch           pixel fetch handshake (master modport of vga_timing_engine_if)
//   pattern_en      selects the built-in test pattern (only with the macro below)
//   hsync/vsync     sync outputs, asserted level set by HSYNC_POL/VSYNC_POL
//   de              display enable
//   r/g/b           output colour
//   line_start      one-clk pulse when the output stage shows column 0
//   frame_start     one-clk pulse when the output stage shows column 0, row 0
//   underrun        one-clk pulse when an active pixel had no valid data
//   underrun_sticky latched underrun, cleared by reset or frame_start
// Build option: define VGA_TEST_PATTERN_EN to include the test pattern
// generator; without it pattern_en is ignored.
module vga_timing_engine #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int PIX_DIV   = 1,
  parameter int FETCH_LAT = 2,
  parameter int COLOR_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  vga_timing_engine_if.master fetch,
  input  logic                pattern_en,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic [COLOR_W-1:0]  r,
  output logic [COLOR_W-1:0]  g,
  output logic [COLOR_W-1:0]  b,
  output logic                line_start,
  output logic                frame_start,
  output logic                underrun,
  output logic                underrun_sticky
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  localparam int          DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  // One pipeline entry. vld distinguishes real positions from the cleared
  // entries left by reset, so those never fire line_start/frame_start.
  typedef struct packed {
    logic        vld;
    logic        de;
    logic        hs;
    logic        vs;
    logic [10:0] x;
    logic [10:0] y;
  } stage_t;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [10:0]        h_q, h_d;
  logic [10:0]        v_q, v_d;
  logic               tick;
  logic               active;

  logic               req_valid_q;
  logic [10:0]        req_x_q, req_y_q;

  stage_t             pipe_q [FETCH_LAT];
  stage_t             stage_in;
  stage_t             pipe_out;

  logic               hsync_q, vsync_q, de_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic               line_start_q, frame_start_q;
  logic               underrun_q, sticky_q;

  logic [COLOR_W-1:0] src_r, src_g, src_b;
  logic               src_ok;
  logic               pix_miss;
  logic               pix_show;
  logic               ls_d, fs_d;
  logic [COLOR_W-1:0] r_d, g_d, b_d;

  // Divider and raster counters
  always_comb begin
    tick   = (div_q == DIV_LAST);
    div_d  = tick ? '0 : div_q + 1'b1;
    h_d    = (h_q == H_LAST) ? '0 : h_q + 11'd1;
    v_d    = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
    end
    active = (h_q < H_ACT) && (v_q < V_ACT);
  end

  // Raw timing for the current position
  always_comb begin
    stage_in.vld = 1'b1;
    stage_in.de  = active;
    stage_in.hs  = (h_q >= HS_BEG) && (h_q < HS_END);
    stage_in.vs  = (v_q >= VS_BEG) && (v_q < VS_END);
    stage_in.x   = h_q;
    stage_in.y   = v_q;
  end

  assign pipe_out = pipe_q[FETCH_LAT-1];

  // Colour source selection
  always_comb begin
    src_r  = fetch.in_r;
    src_g  = fetch.in_g;
    src_b  = fetch.in_b;
    src_ok = fetch.in_valid;
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_en) begin
      src_r  = COLOR_W'(pipe_out.x);
      src_g  = COLOR_W'(pipe_out.x >> COLOR_W);
      src_b  = COLOR_W'(pipe_out.y);
      src_ok = 1'b1;
    end
`endif
  end

`ifndef VGA_TEST_PATTERN_EN
  logic unused_pattern_en;
  assign unused_pattern_en = pattern_en;
`endif

  // Output stage decisions for the delayed position
  always_comb begin
    pix_miss = pipe_out.de & ~src_ok;
    pix_show = pipe_out.de & src_ok;
    r_d      = pix_show ? src_r : '0;
    g_d      = pix_show ? src_g : '0;
    b_d      = pix_show ? src_b : '0;
    ls_d     = pipe_out.vld && (pipe_out.x == '0);
    fs_d     = ls_d && (pipe_out.y == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      req_valid_q   <= 1'b0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      for (int unsigned i = 0; i < FETCH_LAT; i++) begin
        pipe_q[i] <= '0;
      end
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      de_q          <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      sticky_q      <= 1'b0;
    end else begin
      div_q         <= div_d;
      req_valid_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      if (tick) begin
        h_q         <= h_d;
        v_q         <= v_d;
        req_valid_q <= active;
        if (active) begin
          req_x_q <= h_q;
          req_y_q <= v_q;
        end
        for (int unsigned i = FETCH_LAT - 1; i > 0; i--) begin
          pipe_q[i] <= pipe_q[i-1];
        end
        pipe_q[0]     <= stage_in;
        hsync_q       <= HS_ON ? pipe_out.hs : ~pipe_out.hs;
        vsync_q       <= VS_ON ? pipe_out.vs : ~pipe_out.vs;
        de_q          <= pipe_out.de;
        r_q           <= r_d;
        g_q           <= g_d;
        b_q           <= b_d;
        line_start_q  <= ls_d;
        frame_start_q <= fs_d;
        underrun_q    <= pix_miss;
        // A new underrun on the frame_start pixel keeps the flag set.
        sticky_q      <= pix_miss | (sticky_q & ~fs_d);
      end
    end
  end

  assign fetch.req_valid = req_valid_q;
  assign fetch.req_x     = req_x_q;
  assign fetch.req_y     = req_y_q;

  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign de              = de_q;
  assign r               = r_q;
  assign g               = g_q;
  assign b               = b_q;
  assign line_start      = line_start_q;
  assign frame_start     = frame_start_q;
  assign underrun        = underrun_q;
  assign underrun_sticky = sticky_q;

endmodule

// File: doc/vga_timing_engine.md
VGA_TIMING_ENGINE -- requirements
Module: vga_timing_engine

Interface
- REQ-001 SHALL have parameter H_ACTIVE, default 800: visible pixels per line.
- REQ-002 SHALL have parameters H_FP 40, H_SYNC 128, H_BP 88: horizontal porches and sync width in pixels; H_TOTAL = sum of the four horizontal parameters = 1056.
- REQ-003 SHALL have parameters V_ACTIVE 600, V_FP 1, V_SYNC 4, V_BP 23: vertical timing in lines; V_TOTAL = sum of the four vertical parameters = 628.
- REQ-004 SHALL have parameters HSYNC_POL 1 and VSYNC_POL 1: sync asserted level (1 = active-high).
- REQ-005 SHALL have parameter PIX_DIV, default 1, range 1..16: clk cycles per pixel tick.
- REQ-006 SHALL have parameter FETCH_LAT, default 2, range 1..8: pixel ticks between request and data sample.
- REQ-007 SHALL have parameter COLOR_W, default 4: bits per colour channel.
- REQ-008 SHALL have ports, reset synchronous, active-low; clock clk:
  - clk  in  1  clock
  - reset  in  1  synchronous active-low reset
  - req_valid  out  1  pixel fetch request strobe
  - req_x  out  11  requested column
  - req_y  out  11  requested row
  - in_valid  in  1  source data valid
  - in_r/in_g/in_b  in  COLOR_W each  source colour
  - pattern_en  in  1  test pattern select
  - hsync  out  1  horizontal sync
  - vsync  out  1  vertical sync
  - de  out  1  display enable
  - r/g/b  out  COLOR_W each  output colour
  - line_start  out  1  one-clk pulse at column 0 of each line
  - frame_start  out  1  one-clk pulse at column 0, row 0
  - underrun  out  1  one-clk pulse on missing data
  - underrun_sticky  out  1  latched underrun flag

Function
- REQ-009 SHALL generate a tick on every clk in which the divider equals PIX_DIV-1; the divider then wraps to 0. With PIX_DIV=1, every clk is a tick.
- REQ-010 On each tick, the h counter SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and increment the v counter. The v counter SHALL wrap from V_TOTAL-1 to 0.
- REQ-011 req_valid SHALL be high for exactly the one clk after a tick whose pre-increment position lies inside the active region (h<H_ACTIVE, v<V_ACTIVE). req_x/req_y SHALL carry that position and hold otherwise.
- REQ-012 Raw sync/de for a position SHALL be derived as follows:
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - Raw sync/de SHALL pass through a FETCH_LAT-stage shift pipeline that advances only on ticks.
- REQ-013 On the tick FETCH_LAT ticks after a request, the following SHALL be registered from the pipeline output: hsync, vsync, de and colour. Polarity SHALL be applied per HSYNC_POL/VSYNC_POL.
- REQ-014 Colour SHALL be forced to 0 when the delayed de is 0.
- REQ-015 If the delayed de=1 and in_valid=0 at the sample tick:
  - Colour output SHALL be 0.
  - underrun SHALL pulse for 1 clk.
  - underrun_sticky SHALL set.
- REQ-016 underrun_sticky SHALL clear only on reset or on the frame_start pulse. If both coincide with a new underrun, set SHALL win.
- REQ-017 line_start/frame_start SHALL pulse aligned with the output stage, i.e. when the delayed position is h=0, or h=0 and v=0 respectively.
- REQ-018 Outputs SHALL hold their values between ticks.

Reset
- REQ-019 While reset=0, on a clk edge the following SHALL be cleared:
  - divider, counters and pipeline to 0;
  - de, colour, req_valid, line_start, frame_start, underrun and underrun_sticky to 0;
  - hsync/vsync to their inactive levels.
- REQ-020 Reset asserted mid-line SHALL abort the frame. The first post-reset tick SHALL process position (0,0).

Configuration
- REQ-021 With macro VGA_TEST_PATTERN_EN defined and pattern_en=1, source data SHALL be replaced by a test pattern, and in_valid SHALL be ignored (no underrun). The pattern is:
  - r = x[COLOR_W-1:0]
  - g = x[2*COLOR_W-1:COLOR_W]
  - b = y[COLOR_W-1:0]
  - x and y are the delayed position.
- REQ-022 Without VGA_TEST_PATTERN_EN, pattern_en SHALL be ignored and no pattern logic SHALL be synthesised.

Verification
- REQ-023 Defaults, PIX_DIV=1, in_valid=1: hsync high for exactly 128 clk per line; line period 1056 clk; vsync high for 4 lines; frame period 663168 clk.
- REQ-024 FETCH_LAT=2: request (0,0) on the first post-reset tick; frame_start and de=1 exactly 2 ticks later, with r/g/b equal to the in_* values on that tick.
- REQ-025 PIX_DIV=4: req_valid pulses spaced 4 clk apart; hsync width 512 clk.
- REQ-026 in_valid=0 for a single active pixel: one underrun pulse and output 0 for that pixel; sticky set, then cleared at the next frame_start.
- REQ-027 reset=0 at h=500, v=300: all outputs reset on that edge; after release, next request is (0,0).
- REQ-028 VGA_TEST_PATTERN_EN defined, pattern_en=1: pixel (0x35,0x07) outputs r=5, g=3, b=7; no underrun while in_valid=0.
